// File: rtl/rca_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : rca_pipe_addsub
// Description : Pipelined ripple-carry adder/subtractor. The WIDTH-bit chain
//               is cut into STAGES registered segments of WIDTH/STAGES bits.
//               Operands skew forward, finished sum bits de-skew forward, and
//               the whole result leaves together with carry-out and signed
//               overflow. A single global enable stalls every stage when the
//               output holds an unaccepted result.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int c_SEG  = WIDTH / STAGES;
    localparam int c_LAST = STAGES - 1;

    // Stage inputs: stage 0 sees the ports, stage k sees stage k-1 registers.
    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_b_in   [STAGES];
    logic [WIDTH-1:0] w_s_in   [STAGES];
    logic             w_c_in   [STAGES];
    logic             w_sub_in [STAGES];
    logic             w_v_in   [STAGES];

    // Per-stage segment arithmetic and the partial sum it produces.
    logic [c_SEG-1:0] w_bx     [STAGES];
    logic [c_SEG:0]   w_sum    [STAGES];
    logic [WIDTH-1:0] w_s_nx   [STAGES];
    logic             w_ovf_nx;
    logic             w_en;

    // Pipeline registers; the last entry of each array is the output stage.
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic             r_c   [STAGES];
    logic             r_sub [STAGES];
    logic             r_v   [STAGES];
    logic             r_ovf;

    // Everything advances unless a valid result is waiting on the consumer.
    assign w_en      = !(r_v[c_LAST] && !out_ready);
    assign in_ready  = w_en;
    assign out_valid = r_v[c_LAST];
    assign s         = r_s[c_LAST];
    assign cout      = r_c[c_LAST];
    assign ovf       = r_ovf;

    // Route stage inputs and ripple each stage's own segment of the chain.
    always_comb begin
        w_a_in[0]   = a;
        w_b_in[0]   = b;
        w_s_in[0]   = '0;
        // Subtract is a + ~b + ~cin, so the borrow-in becomes an inverted carry.
        w_c_in[0]   = cin ^ sub;
        w_sub_in[0] = sub;
        w_v_in[0]   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_a_in[k]   = r_a[k-1];
            w_b_in[k]   = r_b[k-1];
            w_s_in[k]   = r_s[k-1];
            w_c_in[k]   = r_c[k-1];
            w_sub_in[k] = r_sub[k-1];
            w_v_in[k]   = r_v[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            // b travels unmodified; inversion for subtract happens per segment.
            w_bx[k]   = w_b_in[k][k*c_SEG +: c_SEG] ^ {c_SEG{w_sub_in[k]}};
            w_sum[k]  = {1'b0, w_a_in[k][k*c_SEG +: c_SEG]} + {1'b0, w_bx[k]}
                      + {{c_SEG{1'b0}}, w_c_in[k]};
            w_s_nx[k] = w_s_in[k];
            w_s_nx[k][k*c_SEG +: c_SEG] = w_sum[k][c_SEG-1:0];
        end
        // Signed overflow: operands agree in sign but the result does not.
        w_ovf_nx = (w_a_in[c_LAST][WIDTH-1] == (w_b_in[c_LAST][WIDTH-1] ^ w_sub_in[c_LAST]))
                && (w_s_nx[c_LAST][WIDTH-1] != w_a_in[c_LAST][WIDTH-1]);
    end

    // Shift all stages together on enable; reset clears valids and outputs at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_s[k]   <= '0;
                r_c[k]   <= 1'b0;
                r_sub[k] <= 1'b0;
                r_v[k]   <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= w_a_in[k];
                r_b[k]   <= w_b_in[k];
                r_s[k]   <= w_s_nx[k];
                r_c[k]   <= w_sum[k][c_SEG];
                r_sub[k] <= w_sub_in[k];
                r_v[k]   <= w_v_in[k];
            end
            r_ovf <= w_ovf_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rca_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_pipe_addsub
// Description : Scoreboard bench for rca_pipe_addsub. Three 8-bit instances
//               (4, 1 and 8 stages) share operand inputs; each send pushes an
//               expected result, a monitor pops and compares on transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_pipe_addsub;

    typedef struct {
        int         inst;
        logic [7:0] s;
        logic       c;
        logic       o;
        logic       chk;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic       cin, sub;
    logic       iv   [3];
    logic       ordy [3];
    logic       rdy  [3];
    logic       o_v  [3];
    logic [7:0] o_s  [3];
    logic       o_c  [3];
    logic       o_o  [3];

    exp_t q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic abort = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rca_pipe_addsub #(.WIDTH(8), .STAGES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(o_v[0]), .out_ready(ordy[0]),
        .s(o_s[0]), .cout(o_c[0]), .ovf(o_o[0]));
    rca_pipe_addsub #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(o_v[1]), .out_ready(ordy[1]),
        .s(o_s[1]), .cout(o_c[1]), .ovf(o_o[1]));
    rca_pipe_addsub #(.WIDTH(8), .STAGES(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(o_v[2]), .out_ready(ordy[2]),
        .s(o_s[2]), .cout(o_c[2]), .ovf(o_o[2]));

    function automatic int lat_of(input int i);
        if (i == 0) return 4;
        if (i == 1) return 1;
        return 8;
    endfunction

    // Integer reference: unsigned result for s/cout, signed range for ovf.
    function automatic void model(input logic [7:0] va, vb, input logic vc, vs,
                                  output logic [7:0] es, output logic ec, eo);
        int ua, ub, r, sa, sb, sr;
        ua = int'(va); ub = int'(vb);
        sa = int'($signed(va)); sb = int'($signed(vb));
        if (!vs) begin
            r  = ua + ub + int'(vc);
            ec = (r > 255);
            sr = sa + sb + int'(vc);
        end else begin
            r  = ua - ub - int'(vc);
            ec = (r >= 0);
            sr = sa - sb - int'(vc);
        end
        es = r[7:0];
        eo = (sr > 127) || (sr < -128);
    endfunction

    task automatic send(input int inst, input logic [7:0] va, vb, input logic vc, vs,
                        input logic [7:0] es, input logic ec, eo, input logic chk);
        exp_t e;
        int   t;
        a = va; b = vb; cin = vc; sub = vs; iv[inst] = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (abort) begin iv[inst] = 1'b0; return; end
            if (rdy[inst]) break;
            t++;
            if (t > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout inst%0d: in_ready stuck at %b, required 1", inst, rdy[inst]);
                iv[inst] = 1'b0;
                return;
            end
        end
        e.inst = inst; e.s = es; e.c = ec; e.o = eo; e.chk = chk; e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        iv[0] = 1'b0; iv[1] = 1'b0; iv[2] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        iv[0] = 1'b0; iv[1] = 1'b0; iv[2] = 1'b0;
        t = 0;
        while (q.size() != 0 && t < 40) begin @(posedge clk); t++; end
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: every transfer must match the oldest expected entry.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (o_v[i] && ordy[i]) begin
                    n_cmp++;
                    if (q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected inst%0d: got s=%h cout=%b ovf=%b, required no result",
                                 i, o_s[i], o_c[i], o_o[i]);
                    end else begin
                        e = q.pop_front();
                        if (e.inst != i || o_s[i] !== e.s || o_c[i] !== e.c || o_o[i] !== e.o ||
                            (e.chk && (cyc + 1 - e.acc) != lat_of(i))) begin
                            n_bad++;
                            $display("FAIL result inst%0d: got s=%h cout=%b ovf=%b lat=%0d, required inst%0d s=%h cout=%b ovf=%b lat=%0d",
                                     i, o_s[i], o_c[i], o_o[i], cyc + 1 - e.acc,
                                     e.inst, e.s, e.c, e.o, lat_of(e.inst));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] es;
        logic       ec, eo;
        rst = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b1; end
        #1;
        n_cmp++;
        if (o_v[0] !== 1'b0 || o_s[0] !== 8'h00 || o_c[0] !== 1'b0 || o_o[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: got v=%b s=%h c=%b o=%b rdy=%b, required 0 00 0 0 1",
                     o_v[0], o_s[0], o_c[0], o_o[0], rdy[0]);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // All-ones plus one wraps with carry-out through every boundary.
        send(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        drain();

        // Back-to-back: positive overflow, then a borrowing subtract.
        send(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        send(0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
        // Bubble, then subtract with borrow-in and signed-overflowing subtract.
        idle(1);
        send(0, 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b1);
        send(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
        send(0, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        drain();

        // Full stream a=b with toggling cin, one per cycle.
        for (int k = 0; k < 256; k++) begin
            model(8'(k), 8'(k), k[0], 1'b0, es, ec, eo);
            send(0, 8'(k), 8'(k), k[0], 1'b0, es, ec, eo, 1'b1);
        end
        drain();

        // Mid-stream stall: outputs frozen on the head result, input blocked.
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    model(8'(k * 37), 8'(200 - k * 11), k[1], k[0], es, ec, eo);
                    send(0, 8'(k * 37), 8'(200 - k * 11), k[1], k[0], es, ec, eo, 1'b0);
                end
                iv[0] = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 ordy[0] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    n_cmp++;
                    if (q.size() == 0) begin
                        n_bad++;
                        $display("FAIL stall_hold: scoreboard empty during stall, required head entry");
                    end else if (rdy[0] !== 1'b0 || o_v[0] !== 1'b1 || o_s[0] !== q[0].s ||
                                 o_c[0] !== q[0].c || o_o[0] !== q[0].o) begin
                        n_bad++;
                        $display("FAIL stall_hold: got rdy=%b v=%b s=%h c=%b o=%b, required 0 1 %h %b %b",
                                 rdy[0], o_v[0], o_s[0], o_c[0], o_o[0], q[0].s, q[0].c, q[0].o);
                    end
                end
                @(posedge clk); #1 ordy[0] = 1'b1;
            end
        join
        drain();

        // Asynchronous reset mid-stream discards everything in flight.
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    if (abort) break;
                    model(8'(k + 100), 8'(k * 3), 1'b1, 1'b0, es, ec, eo);
                    send(0, 8'(k + 100), 8'(k * 3), 1'b1, 1'b0, es, ec, eo, 1'b1);
                end
                iv[0] = 1'b0;
            end
            begin
                repeat (7) @(posedge clk);
                #3 rst = 1'b1;
                #1;
                n_cmp++;
                if (o_v[0] !== 1'b0 || o_s[0] !== 8'h00 || o_c[0] !== 1'b0 || o_o[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL async_reset: got v=%b s=%h c=%b o=%b, required 0 00 0 0",
                             o_v[0], o_s[0], o_c[0], o_o[0]);
                end
                abort = 1'b1;
            end
        join
        q.delete();
        @(posedge clk); #2 rst = 1'b0; abort = 1'b0;
        idle(12);
        send(0, 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 1'b1);
        drain();

        // Carry chain on the single-stage and one-bit-per-stage variants.
        send(1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        send(1, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        drain();
        send(2, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        send(2, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        send(2, 8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
